// File: rtl/mem_bus_master.sv
`default_nettype none
// ============================================================================
// mem_bus_master : C2 bus initiator, moves one cache line per cache request
// Rev 1.0
// ============================================================================
module mem_bus_master #(
  parameter int MEM_ADDR_SIZE     = 19,
  parameter int CACHE_OFFSET_SIZE = 4,
  parameter int BUS_SIZE          = 16,
  parameter int CACHE_LINE_SIZE   = 16,
  parameter int TIMEOUT           = 64
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       req_valid,
  output logic                                       req_ready,
  input  logic                                       req_write,
  input  logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] req_addr,
  input  logic [CACHE_LINE_SIZE*8-1:0]               req_wdata,
  output logic                                       resp_valid,
  output logic                                       resp_error,
  output logic [CACHE_LINE_SIZE*8-1:0]               resp_rdata,
  output logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] mem_addr,
  inout  wire  [BUS_SIZE-1:0]                        mem_data,
  inout  wire  [1:0]                                 mem_cmd
);

  localparam int LINE_BITS = CACHE_LINE_SIZE * 8;
  localparam int BEATS     = LINE_BITS / BUS_SIZE;
  localparam int IDX_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W     = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] CMD_NOP      = 2'd0;
  localparam logic [1:0] CMD_RESPONSE = 2'd1;
  localparam logic [1:0] CMD_READ     = 2'd2;
  localparam logic [1:0] CMD_WRITE    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_WAIT = 3'd2,
    S_XFER = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                      state;
  state_t                      state_next;
  logic                        is_write;
  logic                        err;
  logic [IDX_W-1:0]            idx;
  logic [CNT_W-1:0]            wait_cnt;
  logic [1:0]                  cmd_out;
  logic                        cmd_oe;
  logic [BUS_SIZE-1:0]         data_out;
  logic                        data_oe;
  logic [LINE_BITS-BUS_SIZE-1:0] wshift;
  logic [LINE_BITS-1:0]        line_buf;
  logic                        resp_seen;

  assign mem_cmd   = cmd_oe  ? cmd_out  : {2{1'bz}};
  assign mem_data  = data_oe ? data_out : {BUS_SIZE{1'bz}};
  assign resp_seen = (mem_cmd == CMD_RESPONSE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = S_CMD;
      end
      S_CMD:  state_next = S_WAIT;
      S_WAIT: begin
        if (resp_seen)                    state_next = S_XFER;
        else if (wait_cnt == TIMEOUT_LAST) state_next = S_DONE;
      end
      S_XFER: begin
        if (!resp_seen || idx == IDX_LAST) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Write beats leave through a shift register; read beats enter from the top
  // so that beat 0 ends up in the low bits once the line is complete.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_write   <= 1'b0;
      err        <= 1'b0;
      idx        <= '0;
      wait_cnt   <= '0;
      cmd_out    <= CMD_NOP;
      cmd_oe     <= 1'b0;
      data_out   <= '0;
      data_oe    <= 1'b0;
      wshift     <= '0;
      line_buf   <= '0;
      mem_addr   <= '0;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            is_write <= req_write;
            err      <= 1'b0;
            idx      <= '0;
            mem_addr <= req_addr;
            cmd_oe   <= 1'b1;
            cmd_out  <= req_write ? CMD_WRITE : CMD_READ;
            data_oe  <= req_write;
            data_out <= req_wdata[BUS_SIZE-1:0];
            wshift   <= req_wdata[LINE_BITS-1:BUS_SIZE];
          end
        end
        S_CMD: begin
          cmd_oe   <= 1'b0;
          wait_cnt <= '0;
        end
        S_WAIT: begin
          if (resp_seen) begin
            idx <= IDX_W'(1);
            if (is_write) begin
              data_out <= wshift[BUS_SIZE-1:0];
              wshift   <= {{BUS_SIZE{1'b0}}, wshift[LINE_BITS-BUS_SIZE-1:BUS_SIZE]};
            end else begin
              line_buf <= {mem_data, line_buf[LINE_BITS-1:BUS_SIZE]};
            end
          end else if (wait_cnt == TIMEOUT_LAST) begin
            data_oe <= 1'b0;
            err     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_XFER: begin
          if (resp_seen) begin
            idx <= idx + 1'b1;
            if (is_write) begin
              if (idx != IDX_LAST) begin
                data_out <= wshift[BUS_SIZE-1:0];
                wshift   <= {{BUS_SIZE{1'b0}}, wshift[LINE_BITS-BUS_SIZE-1:BUS_SIZE]};
              end else begin
                data_oe <= 1'b0;
              end
            end else begin
              line_buf <= {mem_data, line_buf[LINE_BITS-1:BUS_SIZE]};
            end
          end else begin
            data_oe <= 1'b0;
            err     <= 1'b1;
          end
        end
        S_DONE: begin
          resp_valid <= 1'b1;
          resp_error <= err;
          if (!err && !is_write) resp_rdata <= line_buf;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_master.sv
`default_nettype none
// ============================================================================
// tb_mem_bus_master : directed bench with a cycle-exact C2 responder model
// Rev 1.0
// ============================================================================
module tb_mem_bus_master;

  localparam int BEATS = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_write = 1'b0;
  logic [14:0]  req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic         resp_valid;
  logic         resp_error;
  logic [127:0] resp_rdata;
  logic [14:0]  mem_addr;
  tri0  [15:0]  mem_data;
  tri0  [1:0]   mem_cmd;

  logic         rsp_cmd_en = 1'b0;
  logic         rsp_data_en = 1'b0;
  logic [15:0]  rsp_data = '0;

  assign mem_cmd  = rsp_cmd_en  ? 2'd1     : 2'bzz;
  assign mem_data = rsp_data_en ? rsp_data : 16'hzzzz;

  mem_bus_master dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_error (resp_error),
    .resp_rdata (resp_rdata),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_cmd    (mem_cmd)
  );

  always #5 clk = ~clk;

  int accepts = 0;
  always @(posedge clk) if (req_valid && req_ready) accepts <= accepts + 1;

  logic [127:0] mem_model [logic [14:0]];

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // Runs one request from a negedge in IDLE; the responder answers nresp beats
  // (0 = never, BEATS = full line). Returns at the negedge where resp_valid is seen.
  task automatic do_txn(input logic wr, input logic [14:0] addr, input logic [127:0] wdata,
                        input int nresp, input logic hold, output int lat);
    logic [127:0] line;
    logic [127:0] seen;
    bit           stop;
    line = mem_model.exists(addr) ? mem_model[addr] : '0;
    seen = '0;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    chk("req_ready_idle", req_ready, 1);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    chk("cmd_drive", mem_cmd, wr ? 2'd3 : 2'd2);
    chk("addr_drive", mem_addr, addr);
    chk("data_at_cmd", mem_data, wr ? wdata[15:0] : 16'h0);
    chk("req_ready_busy", req_ready, 0);
    chk("resp_valid_pulse", resp_valid, 0);
    lat = 0;
    stop = 0;
    for (int k = 1; k <= BEATS + 1 && !stop; k++) begin
      @(negedge clk);
      lat = k;
      chk("addr_stable", mem_addr, addr);
      if (k == 1) chk("cmd_released", mem_cmd, 0);
      if (k <= nresp) begin
        rsp_cmd_en = 1'b1;
        if (wr) begin
          chk("wr_beat", mem_data, wdata[16*(k-1) +: 16]);
          seen[16*(k-1) +: 16] = mem_data;
        end else begin
          rsp_data_en = 1'b1;
          rsp_data    = line[16*(k-1) +: 16];
        end
      end else begin
        rsp_cmd_en  = 1'b0;
        rsp_data_en = 1'b0;
        stop = 1;
        if (wr && k == BEATS + 1) chk("wdata_released", mem_data, 0);
      end
    end
    while (!resp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("resp_valid_seen", resp_valid, 1);
    chk("cmd_idle_at_resp", mem_cmd, 0);
    chk("data_idle_at_resp", mem_data, 0);
    chk("req_ready_at_resp", req_ready, 1);
    if (wr && nresp >= BEATS) mem_model[addr] = seen;
  endtask

  typedef struct {
    logic         wr;
    logic [14:0]  addr;
    logic [127:0] wdata;
    int           nresp;
    logic [127:0] exp_rdata;
    logic         exp_err;
    int           exp_lat;
  } vec_t;

  localparam logic [127:0] L1 = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
  localparam logic [127:0] W2 = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;
  localparam logic [127:0] W6 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] WR = 128'hA7A7_A6A6_A5A5_A4A4_A3A3_A2A2_A1A1_A0A0;

  initial begin
    vec_t vecs [8];
    int   lat;
    int   a0;
    bit   saw_valid;

    mem_model[15'h1234] = L1;
    vecs[0] = '{1'b0, 15'h1234, 128'h0, 8, L1, 1'b0, 10};
    vecs[1] = '{1'b1, 15'h7FFF, W2,     8, L1, 1'b0, 10};
    vecs[2] = '{1'b0, 15'h7FFF, 128'h0, 8, W2, 1'b0, 10};
    vecs[3] = '{1'b0, 15'h0001, 128'h0, 0, W2, 1'b1, 66};
    vecs[4] = '{1'b1, 15'h0002, WR,     0, W2, 1'b1, 66};
    vecs[5] = '{1'b0, 15'h1234, 128'h0, 4, W2, 1'b1, 7};
    vecs[6] = '{1'b1, 15'h0000, W6,     8, W2, 1'b0, 10};
    vecs[7] = '{1'b0, 15'h0000, 128'h0, 8, W6, 1'b0, 10};

    repeat (3) @(negedge clk);
    chk("rst_cmd", mem_cmd, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_valid", resp_valid, 0);
    chk("rst_error", resp_error, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_ready", req_ready, 1);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].nresp, 1'b0, lat);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_error", i), resp_error, vecs[i].exp_err);
      chk($sformatf("vec%0d_rdata", i), resp_rdata, vecs[i].exp_rdata);
    end

    // Reset while a write is in XFER
    req_valid = 1'b1; req_write = 1'b1; req_addr = 15'h0055; req_wdata = WR;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rsp_cmd_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("xfer_beat2_driven", mem_data, 16'hA2A2);
    rsp_cmd_en = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_data", mem_data, 0);
    chk("rst_mid_cmd", mem_cmd, 0);
    chk("rst_mid_addr", mem_addr, 0);
    chk("rst_mid_ready", req_ready, 1);
    saw_valid = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 2) reset = 1'b0;
      if (resp_valid) saw_valid = 1;
    end
    chk("rst_mid_no_resp", saw_valid, 0);
    chk("rst_mid_rdata", resp_rdata, 0);
    do_txn(1'b0, 15'h1234, 128'h0, 8, 1'b0, lat);
    chk("post_rst_latency", lat, 10);
    chk("post_rst_error", resp_error, 0);
    chk("post_rst_rdata", resp_rdata, L1);

    // req_valid held high across two back-to-back reads
    a0 = accepts;
    do_txn(1'b0, 15'h7FFF, 128'h0, 8, 1'b1, lat);
    chk("b2b_first_rdata", resp_rdata, W2);
    do_txn(1'b0, 15'h1234, 128'h0, 8, 1'b0, lat);
    chk("b2b_second_latency", lat, 10);
    chk("b2b_second_rdata", resp_rdata, L1);
    repeat (3) @(negedge clk);
    chk("b2b_accepts", accepts - a0, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

endmodule
`default_nettype wire
